// File: rtl/hog_pkg.sv
// hog_pkg: shared HOG constants, block assembler FSM states and block packing helper.
package hog_pkg;

    localparam int HOG_BIN_COUNT   = 9;
    localparam int HOG_BLOCK_CELLS = 4;
    localparam int HOG_BIN_WIDTH   = 14;
    localparam int HOG_HIST_WIDTH  = HOG_BIN_WIDTH * HOG_BIN_COUNT;
    localparam int HOG_BLOCK_WIDTH = HOG_HIST_WIDTH * HOG_BLOCK_CELLS;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } hog_state_t;

    function automatic logic [HOG_BLOCK_WIDTH-1:0] pack_block(
        input logic [HOG_HIST_WIDTH-1:0] tl,
        input logic [HOG_HIST_WIDTH-1:0] tr,
        input logic [HOG_HIST_WIDTH-1:0] bl,
        input logic [HOG_HIST_WIDTH-1:0] br
    );
        return {br, bl, tr, tl};
    endfunction

endpackage

// File: rtl/cell_row_buffer.sv
// cell_row_buffer: one row of cell histograms; read returns the old entry at addr while it is being overwritten.
module cell_row_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 126,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // No reset: the first row of every frame rewrites all entries before they are read.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/cell_block_assembler.sv
// cell_block_assembler: buffers one row of cell histograms and emits every overlapping 2x2 block {BR,BL,TR,TL}.
// Define CELL_BLOCK_COORD_EN to add block_x/block_y outputs carrying the TL cell coordinates.
module cell_block_assembler
    import hog_pkg::*;
#(
    parameter int OUTPUT_BIN_WIDTH = 14,
    parameter int IMAGE_WIDTH      = 32,
    parameter int IMAGE_HEIGHT     = 32,
    parameter int CELL_SIZE        = 8,
    parameter int HISTOGRAM_WIDTH  = OUTPUT_BIN_WIDTH * 9,
    parameter int BLOCK_WIDTH      = HISTOGRAM_WIDTH * 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [HISTOGRAM_WIDTH-1:0] cell_histogram,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLOCK_WIDTH-1:0]     block_histogram,
    output logic                       out_last
`ifdef CELL_BLOCK_COORD_EN
    ,
    output logic [$clog2(IMAGE_WIDTH/CELL_SIZE)-1:0]  block_x,
    output logic [$clog2(IMAGE_HEIGHT/CELL_SIZE)-1:0] block_y
`endif
);

    localparam int CELLS_X = IMAGE_WIDTH / CELL_SIZE;
    localparam int CELLS_Y = IMAGE_HEIGHT / CELL_SIZE;
    localparam int CXW     = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
    localparam int CYW     = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;
    localparam logic [CXW-1:0] CX_LAST = CXW'(CELLS_X - 1);
    localparam logic [CYW-1:0] CY_LAST = CYW'(CELLS_Y - 1);

    hog_state_t                 state;
    logic [CXW-1:0]             cx;
    logic [CYW-1:0]             cy;
    logic [HISTOGRAM_WIDTH-1:0] old_cell;
    logic [HISTOGRAM_WIDTH-1:0] top_left_reg;
    logic [HISTOGRAM_WIDTH-1:0] left_reg;
    logic [BLOCK_WIDTH-1:0]     packed_blk;
    logic                       accept;
    logic                       load;
    logic                       cx_wrap;
    logic                       frame_end;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign cx_wrap   = cx == CX_LAST;
    assign frame_end = cx_wrap && (cy == CY_LAST);
    assign load      = accept && (state == EMIT) && (cx != '0);

    cell_row_buffer #(
        .DEPTH (CELLS_X),
        .WIDTH (HISTOGRAM_WIDTH),
        .AW    (CXW)
    ) u_row_buf (
        .clk   (clk),
        .we    (accept),
        .addr  (cx),
        .wdata (cell_histogram),
        .rdata (old_cell)
    );

    generate
        if (HISTOGRAM_WIDTH == HOG_HIST_WIDTH && BLOCK_WIDTH == HOG_BLOCK_WIDTH) begin : g_pkg_pack
            assign packed_blk = pack_block(top_left_reg, old_cell, left_reg, cell_histogram);
        end else begin : g_local_pack
            assign packed_blk = {cell_histogram, left_reg, old_cell, top_left_reg};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= FILL;
            cx              <= '0;
            cy              <= '0;
            top_left_reg    <= '0;
            left_reg        <= '0;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            block_histogram <= '0;
`ifdef CELL_BLOCK_COORD_EN
            block_x         <= '0;
            block_y         <= '0;
`endif
        end else begin
            if (accept) begin
                cx    <= cx_wrap ? '0 : cx + 1'b1;
                cy    <= cx_wrap ? ((cy == CY_LAST) ? '0 : cy + 1'b1) : cy;
                state <= (state == FILL && cx_wrap) ? EMIT :
                         (state == EMIT && frame_end) ? FILL : state;
                if (state == EMIT) begin
                    top_left_reg <= old_cell;
                    left_reg     <= cell_histogram;
                end
            end
            // Loads only happen on accept, so a stalled block can never be overwritten.
            if (load) begin
                block_histogram <= packed_blk;
                out_last        <= frame_end;
`ifdef CELL_BLOCK_COORD_EN
                block_x         <= cx - 1'b1;
                block_y         <= cy - 1'b1;
`endif
            end
            out_valid <= load || (out_valid && !out_ready);
        end
    end

endmodule

// File: tb/tb_cell_block_assembler.sv
// tb_cell_block_assembler: table-driven directed scenarios plus randomized scoreboard for cell_block_assembler.
module tb_cell_block_assembler;

    localparam int BINW = 14;
    localparam int HW   = BINW * 9;
    localparam int BW   = HW * 4;
    localparam int CX   = 4;
    localparam int CY   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [HW-1:0] cell_histogram = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] block_histogram;
    logic          out_last;
`ifdef CELL_BLOCK_COORD_EN
    logic [1:0]    block_x;
    logic [1:0]    block_y;
`endif

    always #5 clk = ~clk;

    cell_block_assembler dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .cell_histogram  (cell_histogram),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .block_histogram (block_histogram),
        .out_last        (out_last)
`ifdef CELL_BLOCK_COORD_EN
        ,
        .block_x         (block_x),
        .block_y         (block_y)
`endif
    );

    typedef struct {
        logic [BW-1:0] blk;
        logic          last;
        int            bx;
        int            by;
    } blk_t;

    typedef struct {
        int tl, tr, bl, br;
        bit last;
        int bx, by;
    } vec_t;

    blk_t          exp_q[$];
    blk_t          cap_q[$];
    vec_t          tab[9];
    logic [HW-1:0] frame_cells[CY][CX];
    int            px = 0;
    int            py = 0;
    int            errors = 0;
    int            checks = 0;
    bit            rnd_ready = 1'b0;

    function automatic logic [HW-1:0] mk(input int v);
        logic [HW-1:0] h;
        for (int i = 0; i < 9; i++) h[i*BINW +: BINW] = BINW'(v);
        return h;
    endfunction

    function automatic logic [HW-1:0] rnd_hist();
        logic [HW-1:0] h;
        for (int i = 0; i < 9; i++) h[i*BINW +: BINW] = BINW'($urandom);
        return h;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chkb(input bit ok, input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: keep the whole frame as a 2-D array and form a block whenever a cell completes a 2x2 window.
    initial begin
        blk_t          g, e;
        logic [BW-1:0] held;
        logic          held_last;
        bit            stall;
        stall = 1'b0;
        held = '0;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                px = 0;
                py = 0;
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chkb(block_histogram == held, "stall_hold_block", block_histogram, held);
                    chk(out_last == held_last, "stall_hold_last", int'(out_last), int'(held_last));
                end
                if (out_valid && !out_ready) chk(!in_ready, "stall_in_ready", int'(in_ready), 0);
                if (out_valid && out_ready) begin
                    g.blk = block_histogram;
                    g.last = out_last;
`ifdef CELL_BLOCK_COORD_EN
                    g.bx = int'(block_x);
                    g.by = int'(block_y);
`else
                    g.bx = 0;
                    g.by = 0;
`endif
                    cap_q.push_back(g);
                    if (exp_q.size() == 0) chkb(1'b0, "unexpected_block", block_histogram, '0);
                    else begin
                        e = exp_q.pop_front();
                        chkb(g.blk == e.blk, "sb_block", g.blk, e.blk);
                        chk(g.last == e.last, "sb_last", int'(g.last), int'(e.last));
`ifdef CELL_BLOCK_COORD_EN
                        chk(g.bx == e.bx, "sb_block_x", g.bx, e.bx);
                        chk(g.by == e.by, "sb_block_y", g.by, e.by);
`endif
                    end
                end
                if (in_valid && in_ready) begin
                    frame_cells[py][px] = cell_histogram;
                    if (py >= 1 && px >= 1) begin
                        e.blk = {cell_histogram, frame_cells[py][px-1], frame_cells[py-1][px], frame_cells[py-1][px-1]};
                        e.last = (px == CX - 1) && (py == CY - 1);
                        e.bx = px - 1;
                        e.by = py - 1;
                        exp_q.push_back(e);
                    end
                    px++;
                    if (px == CX) begin
                        px = 0;
                        py = (py + 1) % CY;
                    end
                end
                stall = out_valid && !out_ready;
                held = block_histogram;
                held_last = out_last;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_cell(input logic [HW-1:0] h);
        int n;
        bit ok;
        n = 0;
        in_valid = 1'b1;
        cell_histogram = h;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) chk(1'b0, "accept_timeout", n, 200);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(exp_q.size() == 0 && !out_valid, "drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_table(input int base, input int off);
        logic [BW-1:0] e;
        for (int i = 0; i < 9; i++) begin
            if (base + i < cap_q.size()) begin
                e = {mk(tab[i].br + off), mk(tab[i].bl + off), mk(tab[i].tr + off), mk(tab[i].tl + off)};
                chkb(cap_q[base+i].blk == e, "table_block", cap_q[base+i].blk, e);
                chk(cap_q[base+i].last == tab[i].last, "table_last", int'(cap_q[base+i].last), int'(tab[i].last));
`ifdef CELL_BLOCK_COORD_EN
                chk(cap_q[base+i].bx == tab[i].bx, "table_block_x", cap_q[base+i].bx, tab[i].bx);
                chk(cap_q[base+i].by == tab[i].by, "table_block_y", cap_q[base+i].by, tab[i].by);
`endif
            end
        end
    endtask

    task automatic send_frame(input int off);
        for (int i = 0; i < CX * CY; i++) send_cell(mk(i + 1 + off));
    endtask

    initial begin
        logic [BW-1:0] held;
        for (int by = 0; by < CY - 1; by++)
            for (int bx = 0; bx < CX - 1; bx++) begin
                tab[by*(CX-1)+bx].tl = CX * by + bx + 1;
                tab[by*(CX-1)+bx].tr = CX * by + bx + 2;
                tab[by*(CX-1)+bx].bl = CX * (by + 1) + bx + 1;
                tab[by*(CX-1)+bx].br = CX * (by + 1) + bx + 2;
                tab[by*(CX-1)+bx].last = (bx == CX - 2) && (by == CY - 2);
                tab[by*(CX-1)+bx].bx = bx;
                tab[by*(CX-1)+bx].by = by;
            end

        repeat (3) @(posedge clk);
        #1;
        chk(!out_valid, "reset_out_valid", int'(out_valid), 0);
        chk(!out_last, "reset_out_last", int'(out_last), 0);
        chkb(block_histogram == '0, "reset_block", block_histogram, '0);
        rst = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // Single frame, full throughput.
        cap_q.delete();
        for (int i = 0; i < CX * CY; i++) begin
            send_cell(mk(i + 1));
            if (i == 4) chk(!out_valid, "no_block_before_6th", int'(out_valid), 0);
            if (i == 5) begin
                chk(out_valid, "first_block_latency", int'(out_valid), 1);
                chkb(block_histogram[HW-1:0] == mk(1), "first_tl", {{(BW-HW){1'b0}}, block_histogram[HW-1:0]}, {{(BW-HW){1'b0}}, mk(1)});
            end
        end
        drain();
        chk(cap_q.size() == 9, "frame1_count", cap_q.size(), 9);
        check_table(0, 0);

        // Backpressure right after the first block.
        cap_q.delete();
        for (int i = 0; i < 6; i++) send_cell(mk(i + 1));
        out_ready = 1'b0;
        held = block_histogram;
        fork
            for (int i = 6; i < CX * CY; i++) send_cell(mk(i + 1));
            begin
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    chk(!in_ready, "bp_in_ready", int'(in_ready), 0);
                    chkb(block_histogram == held, "bp_block_stable", block_histogram, held);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk(cap_q.size() == 9, "bp_count", cap_q.size(), 9);
        check_table(0, 0);

        // Two back-to-back frames.
        cap_q.delete();
        send_frame(0);
        send_frame(100);
        drain();
        chk(cap_q.size() == 18, "two_frame_count", cap_q.size(), 18);
        check_table(0, 0);
        check_table(9, 100);

        // Random valid/ready, scoreboard only.
        rnd_ready = 1'b1;
        for (int f = 0; f < 20; f++)
            for (int i = 0; i < CX * CY; i++) begin
                send_cell(rnd_hist());
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset mid-frame, then a clean restart.
        for (int i = 0; i < 7; i++) send_cell(mk(i + 1));
        out_ready = 1'b0;
        chk(out_valid, "pre_reset_valid", int'(out_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk(!out_valid, "async_reset_valid", int'(out_valid), 0);
        chk(!out_last, "async_reset_last", int'(out_last), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        cap_q.delete();
        send_frame(0);
        drain();
        chk(cap_q.size() == 9, "post_reset_count", cap_q.size(), 9);
        check_table(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cell_block_assembler.md
Name: cell_block_assembler

Overview:
- Sits directly downstream of cell_histogram and consumes its 9-bin cell histograms.
- Cells arrive in raster order of cell coordinates.
- Buffers one row of cell histograms and emits every overlapping 2x2 HOG block (stride one cell) as a single wide word for the block-normalisation stage.

Parameters:
- OUTPUT_BIN_WIDTH, 14, width of one histogram bin; matches cell_histogram output.
- IMAGE_WIDTH, 32, image width in pixels.
- IMAGE_HEIGHT, 32, image height in pixels.
- CELL_SIZE, 8, cell edge in pixels. Derived: CELLS_X = IMAGE_WIDTH/CELL_SIZE, CELLS_Y = IMAGE_HEIGHT/CELL_SIZE.
- HISTOGRAM_WIDTH, OUTPUT_BIN_WIDTH*9, width of one cell histogram.
- BLOCK_WIDTH, HISTOGRAM_WIDTH*4, width of one block word.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  cell histogram valid.
- in_ready  out  1  block can accept a cell histogram.
- cell_histogram  in  HISTOGRAM_WIDTH  bin 0 at LSBs.
- out_valid  out  1  block word valid.
- out_ready  in  1  downstream accepts the block word.
- block_histogram  out  BLOCK_WIDTH  {BR, BL, TR, TL}; TL occupies the LSBs.
- out_last  out  1  marks the final block of a frame.

Behaviour:
- Reset (rst=0, async): out_valid=0, out_last=0, block_histogram=0, cx=0, cy=0, state=FILL.
  - Row buffer contents are not cleared; they are don't-care because FILL rewrites every entry.
- Accept condition: in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register; combinational ready path is allowed).
- Counters on each accept:
  - cx increments and wraps at CELLS_X-1.
  - On wrap, cy increments; cy wraps at CELLS_Y-1 back to 0,0. Frames run back-to-back.
- FSM:
  - FILL (cy==0): each accepted cell is written to row_buf[cx]; no output.
  - Leaving FILL: on accepting cx=CELLS_X-1 go to EMIT.
  - EMIT (cy>=1): on every accept, read old row_buf[cx] into top_right and write the new cell into row_buf[cx].
    - If cx>=1, load the output register with TL=top_left_reg, TR=old row_buf[cx], BL=left_reg, BR=incoming cell, and set out_valid.
    - Then top_left_reg <= old row_buf[cx] and left_reg <= incoming cell.
  - Leaving EMIT: on accepting the last cell of the frame go to FILL.
- Latency: block appears one cycle after the accept of its BR cell.
- Blocks per frame: (CELLS_X-1)*(CELLS_Y-1); 9 at defaults.
- out_last=1 only with the block whose BR is (CELLS_X-1, CELLS_Y-1).
- Output transfer: out_valid && out_ready. Without a new load in the same cycle, out_valid clears.
  - Same-cycle transfer plus new load keeps out_valid=1 with the new data (full throughput).
- Stall: while out_valid && !out_ready, block_histogram and out_last hold stable and no cell is accepted.
- Cells with cx==0 in EMIT are consumed with no output and no bubble.
- No arithmetic: pure data movement; bin widths are unchanged.

Optional Feature:
- Macro CELL_BLOCK_COORD_EN.
- Defined: adds outputs block_x [$clog2(CELLS_X)-1:0] and block_y [$clog2(CELLS_Y)-1:0], giving the TL cell coordinates.
  - Registered with block_histogram, reset 0, held during stall.
- Undefined: ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package hog_pkg holds: HOG_BIN_COUNT=9, HOG_BLOCK_CELLS=4, the FSM state enum (FILL, EMIT), and a block packing function (tl,tr,bl,br -> word).
- Sub-module cell_row_buffer: CELLS_X-entry register array of HISTOGRAM_WIDTH, one write port, read of the old value at the same index before the write.

Test Plan:
- Stream 16 cells, all bins of cell (cx,cy) = 4*cy+cx+1, out_ready=1.
  - Expect 9 blocks, the first one cycle after the 6th accept.
  - First block: TL bins=1, TR=2, BL=5, BR=6.
  - Last block: TL=11, TR=12, BL=15, BR=16, with out_last=1 on that block only.
- Backpressure: out_ready=0 for 10 cycles right after the first block.
  - Expect in_ready=0, block_histogram constant, no cell lost.
  - After release, remaining blocks match the golden model.
- Two back-to-back frames, frame 2 values +100.
  - Expect 18 blocks.
  - Frame 2 first block: TL=101, TR=102, BL=105, BR=106; no frame-1 data leaks.
- Random in_valid (50%) and random out_ready (50%), 20 frames: scoreboard against the reference model, zero mismatches.
- Assert rst=0 after 7 cells of a frame, then restart the frame.
  - Expect out_valid=0 immediately (async).
  - Next blocks are computed only from post-reset cells; first block is again TL=1, TR=2, BL=5, BR=6.
- With CELL_BLOCK_COORD_EN defined, run the first scenario.
  - Expected block_x,block_y sequence: (0,0),(1,0),(2,0),(0,1) … (2,2).
